// File: rtl/ws_frame_sched_pkg.sv
// Shared types and constants for the pixel-strip frame scheduler.
package ws_pkg;

  localparam int unsigned WS_MAX_STRIPS = 8;
  localparam int unsigned WS_LED_W      = 9;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GAP,
    SETTLE,
    DRAIN,
    SWAP
  } ws_state_e;

  // Rounds up so the frame rate never exceeds the requested one.
  function automatic int unsigned ws_frame_div(input int unsigned clk_hz,
                                               input int unsigned frame_hz);
    return (clk_hz + frame_hz - 1) / frame_hz;
  endfunction

endpackage

// File: rtl/ws_frame_sched_if.sv
// Scheduler-to-transmitter bank bus: start pulses, bank select, LED counts, busy.
interface ws_frame_sched_if #(
  parameter int unsigned NUM_STRIPS = ws_pkg::WS_MAX_STRIPS,
  parameter int unsigned LED_W      = ws_pkg::WS_LED_W
);

  logic [NUM_STRIPS-1:0]       strip_busy;
  logic [NUM_STRIPS-1:0]       strip_start;
  logic                        strip_bank;
  logic [NUM_STRIPS*LED_W-1:0] strip_leds;

  modport master (
    input  strip_busy,
    output strip_start,
    output strip_bank,
    output strip_leds
  );

  modport slave (
    output strip_busy,
    input  strip_start,
    input  strip_bank,
    input  strip_leds
  );

endinterface

// File: rtl/ws_frame_sched_timer.sv
// Free-running frame counter; tick is high while the count sits at FRAME_DIV-1.
module ws_frame_timer #(
  parameter int unsigned FRAME_DIV = 333334
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ws_frame_sched.sv
// Frame scheduler: staggered strip start pulses, between-frame bank swaps,
// overrun/skip accounting.
module ws_frame_sched
  import ws_pkg::*;
#(
  parameter int unsigned NUM_STRIPS = WS_MAX_STRIPS,
  parameter int unsigned LED_W      = WS_LED_W,
  parameter int unsigned FRAME_DIV  = ws_frame_div(20_000_000, 60),
  parameter int unsigned STAGGER    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_strip,
  input  logic             cfg_en,
  input  logic [LED_W-1:0] cfg_leds,
  input  logic             swap_req,
  output logic             swap_ack,
  ws_frame_sched_if.master strip,
  output logic             frame_tick,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [7:0]       skip_cnt,
  output logic             active
);

  localparam int unsigned   IW       = $clog2(WS_MAX_STRIPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STRIPS - 1);
  localparam logic [7:0]    GAP_LAST = 8'((STAGGER == 0) ? 0 : STAGGER - 1);

  ws_state_e state, next_state;
  logic [IW-1:0] idx, idx_next;
  logic [7:0]    wait_cnt, wait_next;

  logic [NUM_STRIPS-1:0] st_en, act_en, act_mask, sel, start_vec, started;
  logic [LED_W-1:0]      st_leds  [NUM_STRIPS];
  logic [LED_W-1:0]      act_leds [NUM_STRIPS];

  logic tick, busy_hit, launch_ok, last, skip, swap_fire, pending_swap, bank;

  ws_frame_timer #(.FRAME_DIV(FRAME_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    sel      = '0;
    act_mask = '0;
    for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
      sel[i]      = (idx == IW'(i));
      act_mask[i] = act_en[i] && (act_leds[i] != '0);
    end
  end

  assign busy_hit  = |(strip.strip_busy & act_mask);
  assign launch_ok = |(sel & act_mask);
  assign last      = (idx == LAST_IDX);
  assign skip      = tick && ((state != IDLE) || busy_hit);
  assign swap_fire = (state == SWAP) && (pending_swap || swap_req);

  always_comb begin
    next_state = state;
    idx_next   = idx;
    wait_next  = wait_cnt;
    start_vec  = '0;
    unique case (state)
      IDLE: begin
        if (tick && !busy_hit) begin
          next_state = LAUNCH;
          idx_next   = '0;
        end
      end
      LAUNCH: begin
        if (launch_ok) start_vec = sel;
        // A zero stagger skips GAP entirely so starts land on consecutive cycles.
        if (launch_ok && STAGGER != 0) begin
          next_state = GAP;
          wait_next  = '0;
        end else if (last) begin
          next_state = SETTLE;
          wait_next  = '0;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      GAP: begin
        if (wait_cnt == GAP_LAST) begin
          if (last) begin
            next_state = SETTLE;
            wait_next  = '0;
          end else begin
            next_state = LAUNCH;
            idx_next   = idx + IW'(1);
          end
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      SETTLE: begin
        if (wait_cnt == 8'd1) next_state = DRAIN;
        else                  wait_next  = wait_cnt + 8'd1;
      end
      DRAIN: begin
        if ((strip.strip_busy & started) == '0) next_state = SWAP;
      end
      SWAP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      idx      <= idx_next;
      wait_cnt <= wait_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      started      <= '0;
      pending_swap <= 1'b0;
      bank         <= 1'b0;
      overrun      <= 1'b0;
      skip_cnt     <= '0;
    end else begin
      if (state == IDLE && next_state == LAUNCH) started <= '0;
      else                                       started <= started | start_vec;

      // A request landing in the SWAP cycle is consumed by that same swap.
      if (state == SWAP)  pending_swap <= 1'b0;
      else if (swap_req)  pending_swap <= 1'b1;
      if (swap_fire)      bank         <= ~bank;

      if (overrun_clr) begin
        overrun  <= 1'b0;
        skip_cnt <= '0;
      end else if (skip) begin
        overrun <= 1'b1;
        if (skip_cnt != 8'hFF) skip_cnt <= skip_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_en  <= '0;
      act_en <= '0;
      for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
        st_leds[i]  <= '0;
        act_leds[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
        if (cfg_wr && cfg_strip == 3'(i)) begin
          st_en[i]   <= cfg_en;
          st_leds[i] <= cfg_leds;
        end
      end
      if (tick && state == IDLE) begin
        act_en <= st_en;
        for (int unsigned i = 0; i < NUM_STRIPS; i++) act_leds[i] <= st_leds[i];
      end
    end
  end

  always_comb begin
    strip.strip_leds = '0;
    for (int unsigned i = 0; i < NUM_STRIPS; i++) strip.strip_leds[i*LED_W +: LED_W] = act_leds[i];
  end

  assign strip.strip_start = start_vec;
  assign strip.strip_bank  = bank;
  assign swap_ack          = swap_fire;
  assign frame_tick        = tick;
  assign active            = (state != IDLE);

endmodule

// File: tb/tb_ws_frame_sched.sv
// Scoreboarded bench for ws_frame_sched (FRAME_DIV=100, STAGGER=2) plus a 4-strip instance.
`timescale 1ns/1ps
module tb_ws_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cfg_wr, cfg_en, swap_req, swap_ack, frame_tick, overrun, overrun_clr, active;
  logic [2:0] cfg_strip;
  logic [8:0] cfg_leds;
  logic [7:0] skip_cnt;

  logic       cfg_wr4, cfg_en4, swap_req4, swap_ack4, frame_tick4, overrun4, active4;
  logic [2:0] cfg_strip4;
  logic [8:0] cfg_leds4;
  logic [7:0] skip_cnt4;

  ws_frame_sched_if #(.NUM_STRIPS(8), .LED_W(9)) bus8 ();
  ws_frame_sched_if #(.NUM_STRIPS(4), .LED_W(9)) bus4 ();

  ws_frame_sched #(.NUM_STRIPS(8), .LED_W(9), .FRAME_DIV(100), .STAGGER(2)) u8 (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_strip(cfg_strip), .cfg_en(cfg_en),
    .cfg_leds(cfg_leds), .swap_req(swap_req), .swap_ack(swap_ack), .strip(bus8),
    .frame_tick(frame_tick), .overrun(overrun), .overrun_clr(overrun_clr),
    .skip_cnt(skip_cnt), .active(active)
  );

  ws_frame_sched #(.NUM_STRIPS(4), .LED_W(9), .FRAME_DIV(100), .STAGGER(2)) u4 (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr4), .cfg_strip(cfg_strip4), .cfg_en(cfg_en4),
    .cfg_leds(cfg_leds4), .swap_req(swap_req4), .swap_ack(swap_ack4), .strip(bus4),
    .frame_tick(frame_tick4), .overrun(overrun4), .overrun_clr(1'b0),
    .skip_cnt(skip_cnt4), .active(active4)
  );

  int total = 0, bad = 0, cyc = 0, last_tick = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         off;
    logic [7:0] mask;
  } exp_t;
  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Each start pulse must match the oldest expectation: mask and offset from last tick.
  always @(negedge clk) begin
    exp_t e;
    if (frame_tick) last_tick = cyc;
    if (mon_en && bus8.strip_start !== 8'h00) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL start_unexpected got=%h at tick+%0d", bus8.strip_start, cyc - last_tick);
      end else begin
        e = sbq.pop_front();
        if (bus8.strip_start !== e.mask || (cyc - last_tick) != e.off) begin
          bad++;
          $display("FAIL start_sched got=%h at tick+%0d want=%h at tick+%0d",
                   bus8.strip_start, cyc - last_tick, e.mask, e.off);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic cfg_write8(input logic [2:0] s, input logic en, input logic [8:0] leds);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_strip = s; cfg_en = en; cfg_leds = leds;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_write4(input logic [2:0] s, input logic en, input logic [8:0] leds);
    @(negedge clk);
    cfg_wr4 = 1'b1; cfg_strip4 = s; cfg_en4 = en; cfg_leds4 = leds;
    @(negedge clk);
    cfg_wr4 = 1'b0;
  endtask

  task automatic wait_tick8(output int tc);
    tc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_tick) begin tc = cyc; break; end
    end
  endtask

  task automatic wait_idle8(output int ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!active) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cfg_wr = 0; cfg_strip = 0; cfg_en = 0; cfg_leds = 0; swap_req = 0; overrun_clr = 0;
    cfg_wr4 = 0; cfg_strip4 = 0; cfg_en4 = 0; cfg_leds4 = 0; swap_req4 = 0;
    bus8.strip_busy = '0; bus4.strip_busy = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    total++; if (bus8.strip_start !== 8'h00) begin bad++; $display("FAIL reset_start got=%h want=00", bus8.strip_start); end
    total++; if (bus8.strip_bank !== 1'b0) begin bad++; $display("FAIL reset_bank got=%b want=0", bus8.strip_bank); end
    total++; if (bus8.strip_leds !== 72'd0) begin bad++; $display("FAIL reset_leds got=%h want=0", bus8.strip_leds); end
    total++; if ({overrun, skip_cnt} !== 9'd0) begin bad++; $display("FAIL reset_overrun got=%b/%0d want=0/0", overrun, skip_cnt); end
    total++; if ({active, swap_ack, frame_tick} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {active, swap_ack, frame_tick}); end
  endtask

  task automatic test_basic;
    int tc, ok;
    cfg_write8(3'd0, 1'b1, 9'd10);
    cfg_write8(3'd3, 1'b1, 9'd20);
    cfg_write8(3'd7, 1'b1, 9'd30);
    sbq.push_back('{1, 8'h01});
    sbq.push_back('{6, 8'h08});
    sbq.push_back('{12, 8'h80});
    wait_tick8(tc);
    total++; if (tc < 0) begin bad++; $display("FAIL basic_tick got=none want=tick within 200"); end
    @(negedge clk);
    total++; if (bus8.strip_leds[0 +: 9] !== 9'd10) begin bad++; $display("FAIL basic_leds0 got=%0d want=10", bus8.strip_leds[0 +: 9]); end
    total++; if (bus8.strip_leds[27 +: 9] !== 9'd20) begin bad++; $display("FAIL basic_leds3 got=%0d want=20", bus8.strip_leds[27 +: 9]); end
    total++; if (bus8.strip_leds[63 +: 9] !== 9'd30) begin bad++; $display("FAIL basic_leds7 got=%0d want=30", bus8.strip_leds[63 +: 9]); end
    wait_idle8(ok);
    total++; if (ok != 1) begin bad++; $display("FAIL basic_idle got=busy want=idle"); end
    total++; if (bus8.strip_bank !== 1'b0) begin bad++; $display("FAIL basic_bank got=%b want=0", bus8.strip_bank); end
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL basic_pending got=%0d want=0 starts outstanding", sbq.size()); end
  endtask

  task automatic test_overrun;
    int tc, s, ok;
    sbq.push_back('{1, 8'h01});
    sbq.push_back('{6, 8'h08});
    sbq.push_back('{12, 8'h80});
    wait_tick8(tc);
    s = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.strip_start[3] === 1'b1) begin s = cyc; break; end
    end
    total++; if (s < 0) begin bad++; $display("FAIL ovr_start3 got=none want=strip3 start"); end
    bus8.strip_busy = 8'h08;
    wait_tick8(tc);
    total++; if (tc < 0) begin bad++; $display("FAIL ovr_tick got=none want=tick"); end
    @(negedge clk);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", overrun); end
    total++; if (skip_cnt !== 8'd1) begin bad++; $display("FAIL ovr_skip got=%0d want=1", skip_cnt); end
    while (cyc < s + 150) @(negedge clk);
    bus8.strip_busy = 8'h00;
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    total++; if ({overrun, skip_cnt} !== 9'd0) begin bad++; $display("FAIL ovr_clr got=%b/%0d want=0/0", overrun, skip_cnt); end
    wait_idle8(ok);
    total++; if (ok != 1) begin bad++; $display("FAIL ovr_idle got=busy want=idle"); end
  endtask

  task automatic test_swap;
    int tc, acks, ack_k;
    logic bank_at_ack;
    sbq.push_back('{1, 8'h01});
    sbq.push_back('{6, 8'h08});
    sbq.push_back('{12, 8'h80});
    wait_tick8(tc);
    acks = 0; ack_k = -1; bank_at_ack = 1'bx;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (swap_ack === 1'b1) begin acks++; ack_k = k; bank_at_ack = bus8.strip_bank; end
      if (k == 1)  bus8.strip_busy = 8'h01;
      if (k == 31) bus8.strip_busy = 8'h00;
      swap_req = (k == 20 || k == 22 || k == 24);
    end
    total++; if (acks != 1) begin bad++; $display("FAIL swap_count got=%0d want=1", acks); end
    total++; if (ack_k != 32) begin bad++; $display("FAIL swap_cycle got=tick+%0d want=tick+32", ack_k); end
    total++; if (bank_at_ack !== 1'b0) begin bad++; $display("FAIL swap_bank_before got=%b want=0", bank_at_ack); end
    total++; if (bus8.strip_bank !== 1'b1) begin bad++; $display("FAIL swap_bank_after got=%b want=1", bus8.strip_bank); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL swap_idle got=%b want=0", active); end
  endtask

  task automatic test_cfg_midframe;
    int tc, acks, ok;
    sbq.push_back('{1, 8'h01});
    sbq.push_back('{6, 8'h08});
    sbq.push_back('{12, 8'h80});
    wait_tick8(tc);
    acks = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (swap_ack === 1'b1) acks++;
      if (k == 4) begin cfg_wr = 1'b1; cfg_strip = 3'd5; cfg_en = 1'b1; cfg_leds = 9'd40; end
      if (k == 5) begin
        cfg_wr = 1'b0;
        total++; if (bus8.strip_leds[45 +: 9] !== 9'd0) begin bad++; $display("FAIL cfg_leds5_early got=%0d want=0", bus8.strip_leds[45 +: 9]); end
      end
    end
    total++; if (acks != 0) begin bad++; $display("FAIL cfg_noswap got=%0d acks want=0", acks); end
    total++; if (bus8.strip_bank !== 1'b1) begin bad++; $display("FAIL cfg_bank_kept got=%b want=1", bus8.strip_bank); end
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL cfg_frame1_pending got=%0d want=0", sbq.size()); end
    sbq.push_back('{1, 8'h01});
    sbq.push_back('{6, 8'h08});
    sbq.push_back('{10, 8'h20});
    sbq.push_back('{14, 8'h80});
    wait_tick8(tc);
    @(negedge clk);
    total++; if (bus8.strip_leds[45 +: 9] !== 9'd40) begin bad++; $display("FAIL cfg_leds5 got=%0d want=40", bus8.strip_leds[45 +: 9]); end
    wait_idle8(ok);
    total++; if (sbq.size() != 0 || ok != 1) begin bad++; $display("FAIL cfg_frame2 got=%0d pending idle=%0d want=0 pending idle=1", sbq.size(), ok); end
  endtask

  task automatic test_rst_gap;
    int tc, r, ok;
    sbq.push_back('{1, 8'h01});
    wait_tick8(tc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    total++; if (bus8.strip_start !== 8'h00) begin bad++; $display("FAIL rst_start got=%h want=00", bus8.strip_start); end
    total++; if (bus8.strip_bank !== 1'b0) begin bad++; $display("FAIL rst_bank got=%b want=0", bus8.strip_bank); end
    total++; if (bus8.strip_leds !== 72'd0) begin bad++; $display("FAIL rst_leds got=%h want=0", bus8.strip_leds); end
    total++; if ({active, swap_ack, frame_tick, overrun} !== 4'b0000) begin bad++; $display("FAIL rst_ctl got=%b want=0000", {active, swap_ack, frame_tick, overrun}); end
    total++; if (skip_cnt !== 8'd0) begin bad++; $display("FAIL rst_skip got=%0d want=0", skip_cnt); end
    cfg_write8(3'd0, 1'b1, 9'd10);
    sbq.push_back('{1, 8'h01});
    wait_tick8(tc);
    total++; if (tc != r + 99) begin bad++; $display("FAIL rst_first_tick got=+%0d want=+99", tc - r); end
    cfg_write8(3'd0, 1'b0, 9'd0);
    wait_idle8(ok);
    total++; if (sbq.size() != 0 || ok != 1) begin bad++; $display("FAIL rst_first_start got=%0d pending idle=%0d want=0 pending idle=1", sbq.size(), ok); end
  endtask

  task automatic test_no_enabled;
    int tc, starts, leds_bad, acks, ack_k;
    cfg_write4(3'd0, 1'b1, 9'd0);
    cfg_write4(3'd7, 1'b1, 9'd33);
    @(negedge clk);
    swap_req4 = 1'b1;
    @(negedge clk);
    swap_req4 = 1'b0;
    tc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_tick4) begin tc = cyc; break; end
    end
    total++; if (tc < 0) begin bad++; $display("FAIL ne_tick got=none want=tick"); end
    starts = 0; leds_bad = 0; acks = 0; ack_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus4.strip_start !== 4'h0) starts++;
      if (bus4.strip_leds !== 36'd0) leds_bad++;
      if (swap_ack4 === 1'b1) begin acks++; ack_k = k; end
    end
    total++; if (starts != 0) begin bad++; $display("FAIL ne_starts got=%0d want=0", starts); end
    total++; if (leds_bad != 0) begin bad++; $display("FAIL ne_leds got=%0d nonzero cycles want=0", leds_bad); end
    total++; if (acks != 1 || ack_k != 8) begin bad++; $display("FAIL ne_swap got=%0d acks at +%0d want=1 at +8", acks, ack_k); end
    total++; if (bus4.strip_bank !== 1'b1) begin bad++; $display("FAIL ne_bank got=%b want=1", bus4.strip_bank); end
    total++; if (active4 !== 1'b0) begin bad++; $display("FAIL ne_idle got=%b want=0", active4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_swap();
    test_cfg_midframe();
    test_rst_gap();
    test_no_enabled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
